// File: rtl/serial_byte_adder.sv
// serial_byte_adder: byte-serial wide adder built around one 8-bit ripple-carry
// adder. Operands arrive LSB byte first on a valid/ready stream. The carry is
// chained between beats, and sum bytes leave through a 1-deep output register.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the in_sub port (A-B mode).

// bitripple: plain 8-bit ripple-carry adder, one full adder per bit.
module bitripple (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   logic [8:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[8];
endmodule

module serial_byte_adder #(
   parameter int MAX_BYTES = 16,
   parameter int CNT_W     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_a,
   input  logic [7:0] in_b,
   input  logic       in_last,
   input  logic       in_cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic       in_sub,
`endif
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_sum,
   output logic       out_last,
   output logic       out_cout,
   output logic       out_err
);
   typedef enum logic {FIRST = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BYTES - 1);
   localparam logic             ONE_BYTE = (MAX_BYTES == 1);

   state_t           state_q, state_d;
   logic             carry_q;
   logic [CNT_W-1:0] byte_cnt;
   logic             accept;
   logic             overflow;
   logic             last_eff;
   logic [7:0]       adder_b;
   logic             adder_cin;
   logic [7:0]       adder_sum;
   logic             adder_cout;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub_q;
   logic             sub_eff;
`endif

   assign in_ready = !out_valid | out_ready;
   assign accept   = in_valid & in_ready;
   assign last_eff = in_last | overflow;

   bitripple u_adder (
      .a    (in_a),
      .b    (adder_b),
      .cin  (adder_cin),
      .sum  (adder_sum),
      .cout (adder_cout)
   );

   // Next state, adder operand/carry selection and overflow detection.
   always_comb begin
      state_d   = state_q;
      adder_b   = in_b;
      adder_cin = carry_q;
      overflow  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      // Subtract mode is latched on the first beat so mid-operand changes are ignored.
      sub_eff = (state_q == FIRST) ? in_sub : sub_q;
      if (sub_eff) adder_b = ~in_b;
`endif
      if (state_q == FIRST) begin
`ifdef SERIAL_ADDER_SUB_EN
         adder_cin = sub_eff ? 1'b1 : in_cin;
`else
         adder_cin = in_cin;
`endif
         overflow = ONE_BYTE & !in_last;
         if (accept && !last_eff) state_d = RUN;
      end else begin
         overflow = (byte_cnt == LAST_CNT) & !in_last;
         if (accept && last_eff) state_d = FIRST;
      end
   end

   // State, carry chain and byte counter; all hold when no beat is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FIRST;
         carry_q  <= 1'b0;
         byte_cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_q    <= 1'b0;
`endif
      end else if (accept) begin
         state_q  <= state_d;
         carry_q  <= adder_cout;
         byte_cnt <= (state_q == FIRST) ? CNT_W'(1) : byte_cnt + CNT_W'(1);
`ifdef SERIAL_ADDER_SUB_EN
         sub_q    <= sub_eff;
`endif
      end
   end

   // 1-deep output register: load on accept, drain on delivery, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= 8'h00;
         out_last  <= 1'b0;
         out_cout  <= 1'b0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_sum   <= adder_sum;
         out_last  <= last_eff;
         out_cout  <= last_eff & adder_cout;
         out_err   <= overflow;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule
